// File: rtl/wakeup_issue_queue.sv
// Out-of-order issue queue with CDB wakeup, enqueue-time bypass and
// lowest-index-first selection of ready entries.
module wakeup_issue_queue #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned TAG_WIDTH   = 6,
   parameter int unsigned INSTR_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       flush,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [INSTR_WIDTH-1:0]     enq_instr,
   input  logic [TAG_WIDTH-1:0]       enq_rd_tag,
   input  logic                       enq_src1_rdy,
   input  logic                       enq_src2_rdy,
   input  logic [DATA_WIDTH-1:0]      enq_src1_val,
   input  logic [DATA_WIDTH-1:0]      enq_src2_val,
   input  logic [TAG_WIDTH-1:0]       enq_src1_tag,
   input  logic [TAG_WIDTH-1:0]       enq_src2_tag,
   input  logic                       cdb_valid,
   input  logic [TAG_WIDTH-1:0]       cdb_tag,
   input  logic [DATA_WIDTH-1:0]      cdb_data,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [INSTR_WIDTH-1:0]     issue_instr,
   output logic [DATA_WIDTH-1:0]      issue_src1,
   output logic [DATA_WIDTH-1:0]      issue_src2,
   output logic [TAG_WIDTH-1:0]       issue_rd_tag,
   output logic [$clog2(DEPTH)-1:0]   issue_idx,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned CntW = IdxW + 1;

   logic [DEPTH-1:0]       alloc_q, alloc_d;
   logic [DEPTH-1:0]       s1_rdy_q, s1_rdy_d;
   logic [DEPTH-1:0]       s2_rdy_q, s2_rdy_d;
   logic [INSTR_WIDTH-1:0] instr_q  [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_d  [DEPTH];
   logic [TAG_WIDTH-1:0]   rd_tag_q [DEPTH];
   logic [TAG_WIDTH-1:0]   rd_tag_d [DEPTH];
   logic [TAG_WIDTH-1:0]   s1_tag_q [DEPTH];
   logic [TAG_WIDTH-1:0]   s1_tag_d [DEPTH];
   logic [TAG_WIDTH-1:0]   s2_tag_q [DEPTH];
   logic [TAG_WIDTH-1:0]   s2_tag_d [DEPTH];
   logic [DATA_WIDTH-1:0]  s1_val_q [DEPTH];
   logic [DATA_WIDTH-1:0]  s1_val_d [DEPTH];
   logic [DATA_WIDTH-1:0]  s2_val_q [DEPTH];
   logic [DATA_WIDTH-1:0]  s2_val_d [DEPTH];
   logic [CntW-1:0]        count_q, count_d;

   logic [DEPTH-1:0]       ready_vec;
   logic                   free_found;
   logic [IdxW-1:0]        free_idx;
   logic                   sel_found;
   logic [IdxW-1:0]        sel_idx;
   logic                   enq_fire;
   logic                   iss_fire;
   logic                   in_s1_rdy, in_s2_rdy;
   logic [DATA_WIDTH-1:0]  in_s1_val, in_s2_val;

   assign enq_ready = (count_q != CntW'(DEPTH));
   assign count     = count_q;
   assign ready_vec = alloc_q & s1_rdy_q & s2_rdy_q;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      sel_found  = 1'b0;
      sel_idx    = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!alloc_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IdxW'(i);
         end
         if (ready_vec[i] && !sel_found) begin
            sel_found = 1'b1;
            sel_idx   = IdxW'(i);
         end
      end
   end

   assign issue_valid = sel_found;
   assign enq_fire    = enq_valid & enq_ready;
   assign iss_fire    = sel_found & issue_ready;

   // A broadcast coinciding with dispatch is captured here, since the
   // entry is not yet allocated and would otherwise miss the wakeup.
   always_comb begin
      in_s1_rdy = enq_src1_rdy;
      in_s1_val = enq_src1_val;
      in_s2_rdy = enq_src2_rdy;
      in_s2_val = enq_src2_val;
      if (!enq_src1_rdy && cdb_valid && (enq_src1_tag == cdb_tag)) begin
         in_s1_rdy = 1'b1;
         in_s1_val = cdb_data;
      end
      if (!enq_src2_rdy && cdb_valid && (enq_src2_tag == cdb_tag)) begin
         in_s2_rdy = 1'b1;
         in_s2_val = cdb_data;
      end
   end

   always_comb begin
      alloc_d  = alloc_q;
      s1_rdy_d = s1_rdy_q;
      s2_rdy_d = s2_rdy_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
         instr_d[i]  = instr_q[i];
         rd_tag_d[i] = rd_tag_q[i];
         s1_tag_d[i] = s1_tag_q[i];
         s2_tag_d[i] = s2_tag_q[i];
         s1_val_d[i] = s1_val_q[i];
         s2_val_d[i] = s2_val_q[i];
         if (cdb_valid && alloc_q[i]) begin
            if (!s1_rdy_q[i] && (s1_tag_q[i] == cdb_tag)) begin
               s1_rdy_d[i] = 1'b1;
               s1_val_d[i] = cdb_data;
            end
            if (!s2_rdy_q[i] && (s2_tag_q[i] == cdb_tag)) begin
               s2_rdy_d[i] = 1'b1;
               s2_val_d[i] = cdb_data;
            end
         end
      end

      // Free slot comes from the current alloc state, so a slot issued this
      // cycle cannot be refilled until the next one.
      if (enq_fire) begin
         alloc_d[free_idx]  = 1'b1;
         instr_d[free_idx]  = enq_instr;
         rd_tag_d[free_idx] = enq_rd_tag;
         s1_rdy_d[free_idx] = in_s1_rdy;
         s1_tag_d[free_idx] = enq_src1_tag;
         s1_val_d[free_idx] = in_s1_val;
         s2_rdy_d[free_idx] = in_s2_rdy;
         s2_tag_d[free_idx] = enq_src2_tag;
         s2_val_d[free_idx] = in_s2_val;
      end

      if (iss_fire) begin
         alloc_d[sel_idx] = 1'b0;
      end

      if (flush) begin
         alloc_d  = '0;
         s1_rdy_d = '0;
         s2_rdy_d = '0;
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({enq_fire, iss_fire})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         alloc_q  <= '0;
         s1_rdy_q <= '0;
         s2_rdy_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            instr_q[i]  <= '0;
            rd_tag_q[i] <= '0;
            s1_tag_q[i] <= '0;
            s2_tag_q[i] <= '0;
            s1_val_q[i] <= '0;
            s2_val_q[i] <= '0;
         end
      end else begin
         alloc_q  <= alloc_d;
         s1_rdy_q <= s1_rdy_d;
         s2_rdy_q <= s2_rdy_d;
         count_q  <= count_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            instr_q[i]  <= instr_d[i];
            rd_tag_q[i] <= rd_tag_d[i];
            s1_tag_q[i] <= s1_tag_d[i];
            s2_tag_q[i] <= s2_tag_d[i];
            s1_val_q[i] <= s1_val_d[i];
            s2_val_q[i] <= s2_val_d[i];
         end
      end
   end

   always_comb begin
      issue_instr  = '0;
      issue_src1   = '0;
      issue_src2   = '0;
      issue_rd_tag = '0;
      issue_idx    = '0;
      if (sel_found) begin
         issue_instr  = instr_q[sel_idx];
         issue_src1   = s1_val_q[sel_idx];
         issue_src2   = s2_val_q[sel_idx];
         issue_rd_tag = rd_tag_q[sel_idx];
         issue_idx    = sel_idx;
      end
   end

endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Directed bench for wakeup_issue_queue: vector table plus hand sequences for
// fill, priority hold, flush and mid-operation reset.
module tb_wakeup_issue_queue;

   localparam int unsigned DW = 32;
   localparam int unsigned D  = 8;
   localparam int unsigned TW = 6;
   localparam int unsigned IW = 32;

   logic          clk;
   logic          resetn;
   logic          flush;
   logic          enq_valid;
   logic          enq_ready;
   logic [IW-1:0] enq_instr;
   logic [TW-1:0] enq_rd_tag;
   logic          enq_src1_rdy, enq_src2_rdy;
   logic [DW-1:0] enq_src1_val, enq_src2_val;
   logic [TW-1:0] enq_src1_tag, enq_src2_tag;
   logic          cdb_valid;
   logic [TW-1:0] cdb_tag;
   logic [DW-1:0] cdb_data;
   logic          issue_valid;
   logic          issue_ready;
   logic [IW-1:0] issue_instr;
   logic [DW-1:0] issue_src1, issue_src2;
   logic [TW-1:0] issue_rd_tag;
   logic [2:0]    issue_idx;
   logic [3:0]    count;

   int passed = 0;
   int total  = 0;

   wakeup_issue_queue #(
      .DATA_WIDTH (DW),
      .DEPTH      (D),
      .TAG_WIDTH  (TW),
      .INSTR_WIDTH(IW)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .flush        (flush),
      .enq_valid    (enq_valid),
      .enq_ready    (enq_ready),
      .enq_instr    (enq_instr),
      .enq_rd_tag   (enq_rd_tag),
      .enq_src1_rdy (enq_src1_rdy),
      .enq_src2_rdy (enq_src2_rdy),
      .enq_src1_val (enq_src1_val),
      .enq_src2_val (enq_src2_val),
      .enq_src1_tag (enq_src1_tag),
      .enq_src2_tag (enq_src2_tag),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_instr  (issue_instr),
      .issue_src1   (issue_src1),
      .issue_src2   (issue_src2),
      .issue_rd_tag (issue_rd_tag),
      .issue_idx    (issue_idx),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int unsigned ev, instr, s1r, s1t, s1v, s2r, s2t, s2v;
      int unsigned cv, ct, cd, ir;
      int unsigned iv, idx, ei, es1, es2, cnt, er;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic drive(input int unsigned ev, input int unsigned instr,
                        input int unsigned s1r, input int unsigned s1t, input int unsigned s1v,
                        input int unsigned s2r, input int unsigned s2t, input int unsigned s2v,
                        input int unsigned cv, input int unsigned ct, input int unsigned cd,
                        input int unsigned ir, input int unsigned fl);
      enq_valid    = ev[0];
      enq_instr    = IW'(instr);
      enq_rd_tag   = TW'(instr);
      enq_src1_rdy = s1r[0];
      enq_src1_tag = TW'(s1t);
      enq_src1_val = DW'(s1v);
      enq_src2_rdy = s2r[0];
      enq_src2_tag = TW'(s2t);
      enq_src2_val = DW'(s2v);
      cdb_valid    = cv[0];
      cdb_tag      = TW'(ct);
      cdb_data     = DW'(cd);
      issue_ready  = ir[0];
      flush        = fl[0];
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_out(input string tag, input int unsigned iv, input int unsigned idx,
                          input int unsigned ei, input int unsigned es1, input int unsigned es2,
                          input int unsigned cnt, input int unsigned er);
      check({tag, " issue_valid"}, 32'(issue_valid), iv);
      check({tag, " issue_idx"}, 32'(issue_idx), idx);
      check({tag, " issue_instr"}, 32'(issue_instr), ei);
      check({tag, " issue_src1"}, 32'(issue_src1), es1);
      check({tag, " issue_src2"}, 32'(issue_src2), es2);
      check({tag, " issue_rd_tag"}, 32'(issue_rd_tag), ei & 32'h3f);
      check({tag, " count"}, 32'(count), cnt);
      check({tag, " enq_ready"}, 32'(enq_ready), er);
   endtask

   initial begin
      // ev instr s1r s1t s1v s2r s2t s2v | cv ct cd | ir || iv idx ei es1 es2 cnt er
      vecs[0]  = '{1, 'hA, 1, 0, 'h11, 1, 0, 'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hA, 'h11, 'h22, 1, 1};
      vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hA, 'h11, 'h22, 1, 1};
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[4]  = '{1, 'hB, 0, 5, 0, 1, 0, 'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'h1234, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hB, 'h1234, 'h22, 1, 1};
      vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[8]  = '{1, 'hC, 1, 0, 'h3, 0, 7, 0, 1, 7, 'h55, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hC, 'h3, 'h55, 1, 1};
      vecs[10] = '{1, 'hD, 1, 3, 'h9, 0, 4, 0, 1, 3, 'hFF, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'hEE, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 'h44, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hD, 'h9, 'h44, 1, 1};
      vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[15] = '{1, 'hE, 1, 0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[16] = '{1, 'hF, 1, 0, 3, 1, 0, 4, 0, 0, 0, 1, 1, 0, 'hE, 1, 2, 1, 1};
      vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'hF, 3, 4, 1, 1};
      vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

      resetn = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      #1;
      chk_out("reset", 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      resetn = 1'b1;

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].ev, vecs[k].instr, vecs[k].s1r, vecs[k].s1t, vecs[k].s1v,
               vecs[k].s2r, vecs[k].s2t, vecs[k].s2v, vecs[k].cv, vecs[k].ct,
               vecs[k].cd, vecs[k].ir, 0);
         #1;
         chk_out($sformatf("vec%0d", k), vecs[k].iv, vecs[k].idx, vecs[k].ei,
                 vecs[k].es1, vecs[k].es2, vecs[k].cnt, vecs[k].er);
      end

      // Fill the queue with entries waiting on tags 10..17.
      for (int i = 0; i < int'(D); i++) begin
         @(negedge clk);
         drive(1, 100 + i, 0, 10 + i, 0, 1, 0, i, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      drive(1, 'h77, 0, 20, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("full count", 32'(count), D);
      check("full enq_ready", 32'(enq_ready), 0);
      check("full issue_valid", 32'(issue_valid), 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 'hAB, 0, 0);
      #1;
      check("extra enq ignored count", 32'(count), D);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      chk_out("full wake", 1, 3, 103, 'hAB, 3, D, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 'hCC, 0, 0);
      #1;
      check("after issue enq_ready", 32'(enq_ready), 1);
      check("after issue count", 32'(count), D - 1);
      @(negedge clk);
      idle();
      #1;
      check("dropped enq never wakes", 32'(issue_valid), 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      idle();
      #1;
      chk_out("flush after fill", 0, 0, 0, 0, 0, 0, 1);

      // Entries 2 and 5 ready; others wait on tags 30+i.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 2 || i == 5) drive(1, 200 + i, 1, 0, 16 * i, 1, 0, 16 * i + 1, 0, 0, 0, 0, 0);
         else drive(1, 200 + i, 0, 30 + i, 0, 0, 30 + i, 0, 0, 0, 0, 0, 0);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle();
         #1;
         chk_out($sformatf("hold%0d", c), 1, 2, 202, 32, 33, 6, 1);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      check("grant idx", 32'(issue_idx), 2);
      @(negedge clk);
      idle();
      #1;
      chk_out("next select", 1, 5, 205, 80, 81, 5, 1);

      // Flush wins over enqueue, wakeup and issue in the same cycle.
      @(negedge clk);
      drive(1, 'h99, 1, 0, 1, 1, 0, 2, 1, 30, 'h5, 1, 1);
      @(negedge clk);
      idle();
      #1;
      chk_out("flush with enq", 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      drive(1, 'h42, 1, 0, 7, 1, 0, 8, 0, 0, 0, 0, 0);
      @(negedge clk);
      drive(1, 'h43, 1, 0, 9, 1, 0, 10, 0, 0, 0, 0, 0);
      #1;
      chk_out("post flush enq", 1, 0, 'h42, 7, 8, 1, 1);
      @(negedge clk);
      idle();
      #1;
      check("pre reset count", 32'(count), 2);

      // Asynchronous reset mid-cycle.
      #2;
      resetn = 1'b0;
      #1;
      chk_out("async reset", 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      drive(1, 'h50, 1, 0, 5, 1, 0, 6, 0, 0, 0, 0, 0);
      @(negedge clk);
      idle();
      #1;
      chk_out("enq after reset", 1, 0, 'h50, 5, 6, 1, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
